// File: rtl/dmem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_responder_pkg
//   Shared definitions for the data-memory responder: the default write-buffer
//   depth and the encoding of the responder's backing-port state machine.
// -----------------------------------------------------------------------------
package dmem_responder_pkg;

  // Write-buffer entries; must be a power of two and at least 2.
  localparam int unsigned WB_DEPTH_DEFAULT = 4;

  // Backing-port sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_REQ  = 2'd1,
    ST_RD_REQ  = 2'd2,
    ST_RD_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/dmem_wbuf.sv
// -----------------------------------------------------------------------------
// dmem_wbuf
//   Posted-write FIFO between the pipeline MEM stage and backing memory.
//   Entries are {word address, data}; no coalescing. A lookup port searches
//   all valid entries and reports the youngest matching entry.
//
//   Ports:
//     clk, rst_n             clock, async active-low reset (empties the FIFO)
//     enq, enq_addr/data     push a word write (ignored when full unless
//                            a dequeue happens in the same cycle)
//     deq                    pop the head entry (ignored when empty)
//     head_addr/head_data    oldest entry
//     empty, full            occupancy flags
//     lookup_addr            word address to search for
//     lookup_hit/data        youngest matching entry, data is 0 on a miss
// -----------------------------------------------------------------------------
module dmem_wbuf
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enq,
  input  logic [29:0] enq_addr,
  input  logic [31:0] enq_data,
  input  logic        deq,
  output logic [29:0] head_addr,
  output logic [31:0] head_data,
  output logic        empty,
  output logic        full,
  input  logic [29:0] lookup_addr,
  output logic        lookup_hit,
  output logic [31:0] lookup_data
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [29:0]   addr_q [DEPTH];
  logic [31:0]   data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q,  count_d;
  logic          enq_ok;
  logic          deq_ok;

  assign full      = (count_q == (PW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_addr = addr_q[rd_ptr_q];
  assign head_data = data_q[rd_ptr_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign deq_ok = deq & ~empty;
  assign enq_ok = enq & (~full | deq_ok);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq_ok) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (deq_ok) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({enq_ok, deq_ok})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Walk oldest to youngest; a later match overrides, so the youngest wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      logic [PW-1:0] idx;
      idx = rd_ptr_q + PW'(i);
      if (((PW+1)'(i) < count_q) && (addr_q[idx] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_q[idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else if (enq_ok) begin
      addr_q[wr_ptr_q] <= enq_addr;
      data_q[wr_ptr_q] <= enq_data;
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Data-memory responder for the pipeline MEM stage. Writes are posted into a
//   write buffer and drained to backing memory in order; reads that hit the
//   buffer return the youngest buffered data in the same cycle; read misses
//   stall the pipeline and fetch from backing memory, taking priority over
//   draining (an already issued drain finishes first).
//
//   Ports:
//     clk, rst_n                       clock, async active-low reset
//     mem_ren, mem_wen                 read / write request (both = write)
//     mem_addr, mem_dout               byte address ([1:0] ignored), write data
//     mem_din                          read data (0 unless hit or read return)
//     mem_stall                        hold the MEM stage while high
//     bk_req, bk_we, bk_addr, bk_wdata backing request, held while bk_req=1
//     bk_ack, bk_rdata                 backing completion pulse and read data
// -----------------------------------------------------------------------------
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned WB_DEPTH = WB_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ren,
  input  logic        mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_dout,
  output logic [31:0] mem_din,
  output logic        mem_stall,
  output logic        bk_req,
  output logic        bk_we,
  output logic [29:0] bk_addr,
  output logic [31:0] bk_wdata,
  input  logic        bk_ack,
  input  logic [31:0] bk_rdata
);

  state_e      state_q,    state_d;
  logic        bk_req_q,   bk_req_d;
  logic        bk_we_q,    bk_we_d;
  logic [29:0] bk_addr_q,  bk_addr_d;
  logic [31:0] bk_wdata_q, bk_wdata_d;
  logic [31:0] rdata_q,    rdata_d;

  logic        stall_c;
  logic [31:0] din_c;

  logic        rd_req;
  logic        wr_req;
  logic        wb_hit;
  logic [31:0] wb_data;
  logic        wb_full;
  logic        wb_empty;
  logic [29:0] wb_head_addr;
  logic [31:0] wb_head_data;
  logic        wb_deq;
  logic        rd_miss;
  logic        unused_addr_lsb;

  // Word access only; the byte offset is deliberately dropped.
  assign unused_addr_lsb = ^mem_addr[1:0];

  // Simultaneous read and write requests are treated as a write only.
  assign wr_req  = mem_wen;
  assign rd_req  = mem_ren & ~mem_wen;
  assign wb_deq  = (state_q == ST_WR_REQ) & bk_ack;
  assign rd_miss = rd_req & ~wb_hit;

  dmem_wbuf #(
    .DEPTH (WB_DEPTH)
  ) u_wbuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .enq         (wr_req),
    .enq_addr    (mem_addr[31:2]),
    .enq_data    (mem_dout),
    .deq         (wb_deq),
    .head_addr   (wb_head_addr),
    .head_data   (wb_head_data),
    .empty       (wb_empty),
    .full        (wb_full),
    .lookup_addr (mem_addr[31:2]),
    .lookup_hit  (wb_hit),
    .lookup_data (wb_data)
  );

  // Backing outputs are registered: the values for a new request are chosen
  // on entry to WR_REQ/RD_REQ and recirculated until the ack.
  always_comb begin
    state_d    = state_q;
    bk_req_d   = 1'b0;
    bk_we_d    = 1'b0;
    bk_addr_d  = '0;
    bk_wdata_d = '0;
    rdata_d    = rdata_q;
    stall_c    = 1'b0;
    din_c      = '0;

    // Full buffer: the write waits unless the head drains this very cycle.
    if (wr_req && wb_full && !wb_deq) begin
      stall_c = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (rd_miss) begin
          state_d   = ST_RD_REQ;
          bk_req_d  = 1'b1;
          bk_addr_d = mem_addr[31:2];
          stall_c   = 1'b1;
        end else if (!wb_empty) begin
          state_d    = ST_WR_REQ;
          bk_req_d   = 1'b1;
          bk_we_d    = 1'b1;
          bk_addr_d  = wb_head_addr;
          bk_wdata_d = wb_head_data;
        end
        if (rd_req && wb_hit) begin
          din_c = wb_data;
        end
      end

      ST_WR_REQ: begin
        if (bk_ack) begin
          state_d = ST_IDLE;
        end else begin
          bk_req_d   = 1'b1;
          bk_we_d    = 1'b1;
          bk_addr_d  = bk_addr_q;
          bk_wdata_d = bk_wdata_q;
        end
        // A miss waits for the drain in flight, then is issued from IDLE.
        if (rd_miss) begin
          stall_c = 1'b1;
        end
        if (rd_req && wb_hit) begin
          din_c = wb_data;
        end
      end

      ST_RD_REQ: begin
        stall_c = 1'b1;
        if (bk_ack) begin
          state_d = ST_RD_DONE;
          rdata_d = bk_rdata;
        end else begin
          bk_req_d  = 1'b1;
          bk_addr_d = bk_addr_q;
        end
      end

      ST_RD_DONE: begin
        state_d = ST_IDLE;
        if (!mem_wen) begin
          din_c = rdata_q;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      bk_req_q   <= 1'b0;
      bk_we_q    <= 1'b0;
      bk_addr_q  <= '0;
      bk_wdata_q <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      bk_req_q   <= bk_req_d;
      bk_we_q    <= bk_we_d;
      bk_addr_q  <= bk_addr_d;
      bk_wdata_q <= bk_wdata_d;
      rdata_q    <= rdata_d;
    end
  end

  // The pipeline-side outputs are combinational, so they are forced quiet
  // directly by rst_n rather than waiting for a reset state to settle.
  assign mem_stall = stall_c & rst_n;
  assign mem_din   = rst_n ? din_c : '0;

  assign bk_req   = bk_req_q;
  assign bk_we    = bk_we_q;
  assign bk_addr  = bk_addr_q;
  assign bk_wdata = bk_wdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

  localparam int unsigned WB_DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        bk_req;
  logic        bk_we;
  logic [29:0] bk_addr;
  logic [31:0] bk_wdata;
  logic        bk_ack;
  logic [31:0] bk_rdata;

  dmem_responder #(
    .WB_DEPTH (WB_DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_ren   (mem_ren),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_dout  (mem_dout),
    .mem_din   (mem_din),
    .mem_stall (mem_stall),
    .bk_req    (bk_req),
    .bk_we     (bk_we),
    .bk_addr   (bk_addr),
    .bk_wdata  (bk_wdata),
    .bk_ack    (bk_ack),
    .bk_rdata  (bk_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [29:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic        wen;
    logic        ren;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_din;
  } vec_t;

  wr_t         exp_wr[$];
  bit          ack_log[$];
  logic [31:0] bmem [logic [29:0]];

  int          ack_delay = 0;
  bit          hold_ack  = 1'b0;
  bit          rd_ovr_en = 1'b0;
  logic [31:0] rd_ovr    = '0;

  function automatic logic [31:0] fill_word(input logic [29:0] a);
    return {2'b00, a} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Backing memory: acks ack_delay cycles after bk_req first rises (0 = same
  // cycle), checks request stability and drain order against the scoreboard.
  initial begin
    int          cnt;
    bit          active;
    logic [62:0] snap;
    cnt = 0; active = 1'b0; snap = '0;
    bk_ack = 1'b0; bk_rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        cnt = 0; active = 1'b0; bk_ack = 1'b0; bk_rdata = '0;
      end else begin
        if (bk_ack) begin
          bk_ack = 1'b0; bk_rdata = '0; cnt = 0;
        end
        if (bk_req) begin
          if (!active) begin
            active = 1'b1;
            snap   = {bk_we, bk_addr, bk_wdata};
          end else begin
            check("bk_hold", 64'({bk_we, bk_addr, bk_wdata}), 64'(snap));
          end
          if (!hold_ack) cnt++;
          if (cnt > ack_delay) begin
            bk_ack = 1'b1;
            active = 1'b0;
            ack_log.push_back(bk_we);
            if (bk_we) begin
              if (exp_wr.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL drain_unexpected: got addr %0h expected none", bk_addr);
              end else begin
                wr_t w;
                w = exp_wr.pop_front();
                check("drain_addr", 64'(bk_addr), 64'(w.addr));
                check("drain_data", 64'(bk_wdata), 64'(w.data));
              end
              bmem[bk_addr] = bk_wdata;
            end else begin
              check("rd_wdata_zero", 64'(bk_wdata), 64'h0);
              if (rd_ovr_en)               bk_rdata = rd_ovr;
              else if (bmem.exists(bk_addr)) bk_rdata = bmem[bk_addr];
              else                          bk_rdata = fill_word(bk_addr);
            end
          end
        end
      end
    end
  end

  // Presents one request and holds it until the DUT stops stalling.
  // Entered and left just after a rising edge.
  task automatic do_op(input logic wen, input logic ren, input logic [31:0] addr,
                       input logic [31:0] data, output logic [31:0] din, output int stalls);
    bit done;
    wr_t w;
    mem_wen = wen; mem_ren = ren; mem_addr = addr; mem_dout = data;
    if (wen) begin
      w.addr = addr[31:2];
      w.data = data;
      exp_wr.push_back(w);
    end
    stalls = 0; din = '0; done = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!mem_stall) begin
        din  = mem_din;
        done = 1'b1;
        break;
      end
      check("din_zero_in_stall", 64'(mem_din), 64'h0);
      stalls++;
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL op_timeout: got stall for %0d cycles expected release", stalls);
    end
    @(posedge clk); #1;
    mem_wen = 1'b0; mem_ren = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (exp_wr.size() == 0 && !bk_req) begin
        done = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_wr.size());
    end
    @(posedge clk); #1;
  endtask

  vec_t vecs[14];

  initial begin
    logic [31:0] d;
    int          s;

    vecs[0]  = '{1'b1, 1'b0, 32'h0000_0200, 32'h1111_0000, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_0204, 32'h2222_0000, 32'h0000_0000};
    vecs[2]  = '{1'b0, 1'b1, 32'h0000_0200, 32'h0,         32'h1111_0000};
    vecs[3]  = '{1'b0, 1'b1, 32'h0000_0204, 32'h0,         32'h2222_0000};
    vecs[4]  = '{1'b1, 1'b0, 32'h0000_0200, 32'h3333_0000, 32'h0000_0000};
    vecs[5]  = '{1'b0, 1'b1, 32'h0000_0200, 32'h0,         32'h3333_0000};
    vecs[6]  = '{1'b0, 1'b1, 32'h0000_0208, 32'h0,         32'h5A5A_0082};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0208, 32'h4444_0000, 32'h0000_0000};
    vecs[8]  = '{1'b0, 1'b1, 32'h0000_0208, 32'h0,         32'h4444_0000};
    vecs[9]  = '{1'b0, 1'b1, 32'h0000_020B, 32'h0,         32'h4444_0000};
    vecs[10] = '{1'b1, 1'b0, 32'h0000_03FC, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[11] = '{1'b0, 1'b1, 32'h0000_03FC, 32'h0,         32'hFFFF_FFFF};
    vecs[12] = '{1'b0, 1'b1, 32'h0000_03F8, 32'h0,         32'h5A5A_00FE};
    vecs[13] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000};

    rst_n = 1'b0; mem_ren = 1'b1; mem_wen = 1'b0; mem_addr = 32'h40; mem_dout = '0;
    #2;
    check("rst_stall",  64'(mem_stall), 64'h0);
    check("rst_din",    64'(mem_din),   64'h0);
    check("rst_bk_req", 64'(bk_req),    64'h0);
    check("rst_bk_out", 64'({bk_we, bk_addr, bk_wdata}), 64'h0);
    repeat (3) @(posedge clk);
    #1;
    mem_ren = 1'b0;
    rst_n   = 1'b1;

    // Table-driven traffic with immediate acks.
    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].wen, vecs[i].ren, vecs[i].addr, vecs[i].data, d, s);
      check($sformatf("vec%0d_din", i), 64'(d), 64'(vecs[i].exp_din));
    end
    drain();

    // Read hit right after a write: same-cycle data, no read request issued.
    hold_ack = 1'b1;
    do_op(1'b1, 1'b0, 32'h10, 32'hAAAA_0001, d, s);
    mem_ren = 1'b1; mem_addr = 32'h10;
    @(negedge clk);
    check("hit_din",       64'(mem_din),          64'hAAAA_0001);
    check("hit_stall",     64'(mem_stall),        64'h0);
    check("hit_no_rd_req", 64'(bk_req & ~bk_we),  64'h0);
    @(posedge clk); #1;
    mem_ren = 1'b0;
    hold_ack = 1'b0;
    drain();

    // Two writes to one address: the youngest is returned.
    hold_ack = 1'b1;
    do_op(1'b1, 1'b0, 32'h20, 32'h1, d, s);
    do_op(1'b1, 1'b0, 32'h20, 32'h2, d, s);
    do_op(1'b0, 1'b1, 32'h20, 32'h0, d, s);
    check("youngest_din",   64'(d), 64'h2);
    check("youngest_stall", 64'(s), 64'h0);
    hold_ack = 1'b0;
    drain();

    // Read miss on empty buffer, ack 3 cycles after bk_req.
    ack_delay = 3; rd_ovr_en = 1'b1; rd_ovr = 32'hDEAD_BEEF;
    do_op(1'b0, 1'b1, 32'h40, 32'h0, d, s);
    check("miss_stall_cycles", 64'(s), 64'd5);
    check("miss_din",          64'(d), 64'hDEAD_BEEF);
    @(negedge clk);
    check("miss_din_one_cycle", 64'(mem_din), 64'h0);
    @(posedge clk); #1;
    ack_delay = 0; rd_ovr_en = 1'b0;

    // Fill the buffer with the drain blocked; the next write stalls until
    // the ack and is accepted in the ack cycle.
    hold_ack = 1'b1;
    for (int i = 0; i < WB_DEPTH; i++) begin
      do_op(1'b1, 1'b0, 32'h100 + 32'(4 * i), 32'hB000_0000 + 32'(i), d, s);
      check($sformatf("fill%0d_stall", i), 64'(s), 64'h0);
    end
    begin
      wr_t w;
      w.addr = 30'h44; w.data = 32'hB000_0004;
      mem_wen = 1'b1; mem_addr = 32'h110; mem_dout = 32'hB000_0004;
      exp_wr.push_back(w);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_stall", 64'(mem_stall), 64'h1);
      if (i == 2) hold_ack = 1'b0;
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("full_accept_stall", 64'(mem_stall), 64'h0);
    check("full_accept_ack",   64'(bk_ack),    64'h1);
    @(posedge clk); #1;
    mem_wen = 1'b0;
    drain();

    // Read miss behind an issued drain: write completes first, then the read.
    ack_log.delete();
    hold_ack = 1'b1;
    do_op(1'b1, 1'b0, 32'h80, 32'hC0DE_0080, d, s);
    @(posedge clk); #1;
    check("wr_pending", 64'({bk_req, bk_we}), 64'h3);
    mem_ren = 1'b1; mem_addr = 32'h84;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("miss_behind_wr_stall", 64'(mem_stall), 64'h1);
      if (i == 2) hold_ack = 1'b0;
      @(posedge clk); #1;
    end
    do_op(1'b0, 1'b1, 32'h84, 32'h0, d, s);
    check("miss_behind_wr_tail", 64'(s), 64'd3);
    check("miss_behind_wr_din",  64'(d), 64'h5A5A_0021);
    check("order_wr_then_rd", 64'({ack_log.size() == 2,
                                   ack_log.size() > 0 ? ack_log[0] : 1'b0,
                                   ack_log.size() > 1 ? ack_log[1] : 1'b1}), 64'h6);
    drain();

    // Reset during RD_REQ with a write still buffered.
    hold_ack = 1'b1;
    do_op(1'b1, 1'b0, 32'hC0, 32'h7777_0030, d, s);
    mem_ren = 1'b1; mem_addr = 32'hC4;
    @(posedge clk); #1;
    check("in_rd_req", 64'({bk_req, bk_we}), 64'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_bk_req", 64'(bk_req),    64'h0);
    check("mid_rst_stall",  64'(mem_stall), 64'h0);
    check("mid_rst_din",    64'(mem_din),   64'h0);
    exp_wr.delete();
    @(posedge clk); #1;
    mem_ren = 1'b0; hold_ack = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(1'b0, 1'b1, 32'hC0, 32'h0, d, s);
    check("post_rst_miss_stall", 64'(s), 64'd2);
    check("post_rst_miss_din",   64'(d), 64'h5A5A_0030);

    drain();
    check("sb_empty", 64'(exp_wr.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter WB_DEPTH, default 4: write-buffer entries, a power of two, minimum 2.
REQ-002 SHALL have ports, in this order:
- clk  in  1  sole clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_ren  in  1  pipeline MEM-stage read request.
- mem_wen  in  1  pipeline MEM-stage write request.
- mem_addr  in  32  byte address; bits [1:0] ignored (word access only).
- mem_dout  in  32  write data from the pipeline.
- mem_din  out  32  read data to the pipeline.
- mem_stall  out  1  pipeline MEM stage SHALL hold while this is high.
- bk_req  out  1  backing-memory request.
- bk_we  out  1  1 = write, 0 = read.
- bk_addr  out  30  backing word address.
- bk_wdata  out  32  backing write data.
- bk_ack  in  1  one-cycle completion pulse.
- bk_rdata  in  32  read data; valid in the bk_ack cycle.
REQ-003 Reset SHALL be asynchronous and active-low on rst_n; clk is the only clock.

Function
REQ-004 Write handling:
- mem_wen with the buffer not full SHALL enqueue {mem_addr[31:2], mem_dout} at the clock edge, with mem_stall=0.
- Writes SHALL NOT be coalesced.
REQ-005 Full-buffer writes:
- Buffer full and no dequeue this cycle: mem_stall SHALL be 1 combinationally until a slot frees.
- Buffer full with a dequeue this cycle (bk_ack on a write): the enqueue SHALL be accepted with mem_stall=0.
REQ-006 Read hit: mem_ren that matches a buffered word address SHALL return the youngest matching entry's data on mem_din in the same cycle, with mem_stall=0.
REQ-007 Read miss: mem_ren with no buffer match SHALL assert mem_stall and fetch the word from backing memory.
REQ-008 The FSM SHALL have states IDLE, WR_REQ, RD_REQ, RD_DONE, with these transitions:
- IDLE->RD_REQ on a read miss.
- IDLE->WR_REQ when the buffer is non-empty and there is no read miss.
- WR_REQ->IDLE on bk_ack (head dequeued).
- RD_REQ->RD_DONE on bk_ack (bk_rdata captured).
- RD_DONE->IDLE unconditionally.
REQ-009 Backing-port arbitration:
- A read miss SHALL take priority over draining.
- A write already issued (WR_REQ) SHALL complete first.
- A read miss arriving during WR_REQ SHALL keep mem_stall=1 and go to RD_REQ after the ack.
REQ-010 Backing handshake:
- bk_req SHALL be 1 exactly in WR_REQ and RD_REQ.
- bk_we, bk_addr and bk_wdata SHALL be held stable while bk_req=1.
- In RD_REQ, bk_wdata SHALL be 0.
REQ-011 Read-miss latency: in RD_DONE, mem_din SHALL be the captured data and mem_stall=0 for exactly one cycle; total stall SHALL equal 2 + (cycles from bk_req to bk_ack).
REQ-012 mem_ren and mem_wen both high: the request SHALL be treated as a write only, with mem_din=0.
REQ-013 mem_din SHALL be 0 whenever the cycle is neither a read hit nor RD_DONE.
REQ-014 Buffer pointers SHALL wrap modulo WB_DEPTH; occupancy SHALL be held in a log2(WB_DEPTH)+1-bit counter.
REQ-015 bk_ack outside WR_REQ/RD_REQ SHALL be ignored.

Reset
REQ-016 While rst_n=0, the following SHALL hold immediately and asynchronously:
- mem_din=0, mem_stall=0.
- bk_req=0, bk_we=0, bk_addr=0, bk_wdata=0.
- FSM=IDLE; buffer empty, pointers 0.
REQ-017 Reset mid-transaction SHALL drop bk_req immediately; buffered writes are discarded.

Structure
REQ-018 The shared package SHALL hold the FSM state encoding and the WB_DEPTH default.
REQ-019 The write buffer SHALL be a sub-module dmem_wbuf: a FIFO with a youngest-first address match port (hit, data) and a full signal.

Verification
REQ-020 Write 0x10/0xAAAA0001, then read 0x10 next cycle -> mem_din=0xAAAA0001 same cycle, mem_stall=0, no bk_req for the read.
REQ-021 Writes to 0x20, then 0x20 again (0x1, 0x2), then read 0x20 -> mem_din=0x2 (youngest entry).
REQ-022 Empty buffer, read 0x40, backing acks 3 cycles after bk_req with 0xDEADBEEF -> mem_stall high 5 cycles, then mem_din=0xDEADBEEF for one cycle.
REQ-023 WB_DEPTH+1 back-to-back writes, ack withheld -> the 5th write stalls; on ack, the 5th is accepted in the ack cycle, and drains occur in FIFO order.
REQ-024 Read miss issued while WR_REQ is pending -> the write completes first (bk_we=1), then the read (bk_we=0), with stall held throughout.
REQ-025 rst_n dropped during RD_REQ -> bk_req=0 and mem_stall=0 with no clock edge; after release, the next read of a previously buffered address misses.
